// File: rtl/alu_pkg.sv
// Shared types for the ALU decode stage: ALU operation encoding, opcode
// constants, operand selects and the registered control word.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } aluctrl_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'b00,
    OP1_PC   = 2'b01,
    OP1_ZERO = 2'b10
  } op1_sel_t;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_t;

  typedef struct packed {
    aluctrl_t        aluctrl;
    op1_sel_t        op1_sel;
    op2_sel_t        op2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } ctrl_t;

  // Base (funct7 = 0) operation selected by funct3, shared by OP and OP-IMM.
  function automatic aluctrl_t funct3_op(input logic [2:0] f3);
    aluctrl_t op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Immediate generator: I-type, U-type and zero-extended shift amount,
// chosen by opcode and funct3. Purely combinational.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_rd_bits;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign unused_rd_bits = ^instr_i[11:7];

  always_comb begin
    imm_o = '0;
    case (opc)
      OPC_OPIMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm_o = {{(XLEN-5){1'b0}}, instr_i[24:20]};
        end else begin
          imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        end
      end
      OPC_LUI, OPC_AUIPC: imm_o = {instr_i[31:12], 12'b0};
      default:            imm_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// One-entry decode pipeline register: RV32I integer ops into the ALU control
// word, with valid/ready on both sides and a redirect flush.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_aluctrl,
  output logic [1:0]      out_op1_sel,
  output logic            out_op2_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_w;
  logic            legal;
  aluctrl_t        alu;
  op1_sel_t        op1;
  op2_sel_t        op2;
  ctrl_t           ctrl_d, ctrl_q;
  logic            valid_q;
  logic            capture;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  imm_gen u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm_w)
  );

  always_comb begin
    legal = 1'b0;
    alu   = ALU_ADD;
    op1   = OP1_RS1;
    op2   = OP2_RS2;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          alu   = funct3_op(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal = 1'b1;
          alu   = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal = 1'b1;
          alu   = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        op2 = OP2_IMM;
        // Shift-immediates reuse the funct7 field; everything else carries imm[11:5] there.
        case (f3)
          3'b001: begin
            legal = (f7 == F7_BASE);
            alu   = ALU_SLL;
          end
          3'b101: begin
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            alu   = in_instr[30] ? ALU_SRA : ALU_SRL;
          end
          default: begin
            legal = 1'b1;
            alu   = funct3_op(f3);
          end
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        op1   = OP1_ZERO;
        op2   = OP2_IMM;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op1   = OP1_PC;
        op2   = OP2_IMM;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_d         = '0;
    ctrl_d.rs1     = in_instr[19:15];
    ctrl_d.rs2     = in_instr[24:20];
    ctrl_d.rd      = in_instr[11:7];
    ctrl_d.pc      = in_pc;
    ctrl_d.illegal = !legal;
    if (legal) begin
      ctrl_d.aluctrl = alu;
      ctrl_d.op1_sel = op1;
      ctrl_d.op2_sel = op2;
      ctrl_d.imm     = imm_w;
      ctrl_d.reg_we  = (in_instr[11:7] != 5'd0);
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_aluctrl = ctrl_q.aluctrl;
  assign out_op1_sel = ctrl_q.op1_sel;
  assign out_op2_sel = ctrl_q.op2_sel;
  assign out_imm     = ctrl_q.imm;
  assign out_rs1     = ctrl_q.rs1;
  assign out_rs2     = ctrl_q.rs2;
  assign out_rd      = ctrl_q.rd;
  assign out_reg_we  = ctrl_q.reg_we;
  assign out_illegal = ctrl_q.illegal;
  assign out_pc      = ctrl_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed encodings, backpressure,
// flush and async reset, then randomized traffic against a reference model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluctrl;
  logic [1:0]  out_op1_sel;
  logic        out_op2_sel;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_we;
  logic        out_illegal;
  logic [31:0] out_pc;

  alu_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluctrl (out_aluctrl),
    .out_op1_sel (out_op1_sel),
    .out_op2_sel (out_op2_sel),
    .out_imm     (out_imm),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_reg_we  (out_reg_we),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu;
    logic [1:0]  op1;
    logic        op2;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mnemonic-level table lookup plus arithmetic immediates.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    int         code;
    int         base[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    logic [6:0] opc = ins[6:0];
    logic [6:0] f7  = ins[31:25];
    logic [2:0] f3  = ins[14:12];
    code  = -1;
    e.imm = 32'd0;
    e.op1 = 2'd0;
    e.op2 = 1'b0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) code = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
    end else if (opc == 7'h13) begin
      e.op2 = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = {27'd0, ins[24:20]};
        if (f7 == 7'h00) code = base[f3];
        else if (f3 == 3'd5 && f7 == 7'h20) code = 7;
      end else begin
        e.imm = $signed(ins) >>> 20;
        code  = base[f3];
      end
    end else if (opc == 7'h37) begin
      code  = 0;
      e.op1 = 2'd2;
      e.op2 = 1'b1;
      e.imm = ins & 32'hFFFF_F000;
    end else if (opc == 7'h17) begin
      code  = 0;
      e.op1 = 2'd1;
      e.op2 = 1'b1;
      e.imm = ins & 32'hFFFF_F000;
    end
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.ill = (code < 0);
    if (e.ill) begin
      e.alu = 4'd0;
      e.imm = 32'd0;
      e.we  = 1'b0;
    end else begin
      e.alu = code[3:0];
      e.we  = (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  // Queue depth tracks the word the stage should be holding.
  always @(negedge clk) begin
    bit exp_vld;
    bit exp_rdy;
    if (rst) begin
      q.delete();
    end else begin
      exp_vld = (q.size() != 0);
      exp_rdy = !exp_vld || out_ready;
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid && exp_vld) begin
        check("aluctrl", {28'd0, out_aluctrl}, {28'd0, q[0].alu});
        check("imm", out_imm, q[0].imm);
        check("rs1", {27'd0, out_rs1}, {27'd0, q[0].rs1});
        check("rs2", {27'd0, out_rs2}, {27'd0, q[0].rs2});
        check("rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        check("reg_we", {31'd0, out_reg_we}, {31'd0, q[0].we});
        check("illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
        check("pc", out_pc, q[0].pc);
        if (!q[0].ill) begin
          check("op1_sel", {30'd0, out_op1_sel}, {30'd0, q[0].op1});
          check("op2_sel", {31'd0, out_op2_sel}, {31'd0, q[0].op2});
        end
      end
      if (flush) begin
        if (exp_vld) void'(q.pop_front());
      end else begin
        if (exp_vld && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          sel;
    ins = $urandom;
    sel = $urandom_range(0, 2);
    case ($urandom_range(0, 5))
      0: begin
        ins[6:0] = 7'h33;
        if (sel == 0) ins[31:25] = 7'h00;
        else if (sel == 1) ins[31:25] = 7'h20;
      end
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h37;
      3: ins[6:0] = 7'h17;
      4: ;
      default: begin
        ins[6:0] = 7'h13;
        if (sel == 0) ins[31:25] = 7'h00;
        else if (sel == 1) ins[31:25] = 7'h20;
      end
    endcase
    return ins;
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst aluctrl", {28'd0, out_aluctrl}, 32'd0);
    check("rst illegal", {31'd0, out_illegal}, 32'd0);
    check("rst imm", out_imm, 32'd0);
    check("rst reg_we", {31'd0, out_reg_we}, 32'd0);
    check("rst pc", out_pc, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-flow directed encodings
    drive(1'b1, 32'h002081B3, 32'h0000_0000, 1'b1, 1'b0);  // add x3,x1,x2
    drive(1'b1, 32'h402081B3, 32'h0000_0004, 1'b1, 1'b0);  // sub
    drive(1'b1, 32'h40335293, 32'h0000_0008, 1'b1, 1'b0);  // srai x5,x6,3
    drive(1'b1, 32'hFFF00093, 32'h0000_000C, 1'b1, 1'b0);  // addi x1,x0,-1
    drive(1'b1, 32'h12345137, 32'h0000_0010, 1'b1, 1'b0);  // lui x2,0x12345
    drive(1'b1, 32'h00001217, 32'h0000_0100, 1'b1, 1'b0);  // auipc x4,1
    drive(1'b1, 32'h00000000, 32'h0000_0104, 1'b1, 1'b0);  // illegal opcode
    drive(1'b1, 32'h4020A1B3, 32'h0000_0108, 1'b1, 1'b0);  // sub-form funct3=010
    drive(1'b1, 32'h00000013, 32'h0000_010C, 1'b1, 1'b0);  // nop, rd=0
    drive(1'b1, 32'h8020D093, 32'h0000_0110, 1'b1, 1'b0);  // bad srli funct7
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: B is offered while A is held and must survive.
    drive(1'b1, 32'h00C5F533, 32'h0000_0200, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 32'h00C5E533, 32'h0000_0204, 1'b0, 1'b0);
    drive(1'b1, 32'h00C5E533, 32'h0000_0204, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a held word and an incoming one, then on an empty stage.
    drive(1'b1, 32'h00C5C533, 32'h0000_0300, 1'b0, 1'b0);
    drive(1'b1, 32'h00C59533, 32'h0000_0304, 1'b0, 1'b1);
    drive(1'b1, 32'h00C5D533, 32'h0000_0308, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Async reset while a word is held.
    drive(1'b1, 32'h00C5A533, 32'h0000_0400, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst aluctrl", {28'd0, out_aluctrl}, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained queue", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that turns a 32-bit RV32I instruction into the control word consumed by the core's ALU: the 4-bit `aluctrl`, operand selects, register indices and the sign-extended immediate. It sits between fetch and execute as a one-entry pipeline register with valid/ready handshakes on both sides and a flush input for branch redirects. It produces exactly the `aluctrl` encoding the ALU interprets.

## Interface
- `XLEN`, 32, datapath and immediate width

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  raw instruction
- `in_pc`  in  XLEN  instruction address
- `flush`  in  1  discard held and incoming instruction
- `out_valid`  out  1  decoded word valid
- `out_ready`  in  1  execute accepts
- `out_aluctrl`  out  4  ALU operation
- `out_op1_sel`  out  2  00 = rs1, 01 = pc, 10 = zero
- `out_op2_sel`  out  1  0 = rs2, 1 = imm
- `out_imm`  out  XLEN  sign-extended immediate
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices
- `out_reg_we`  out  1  destination write enable
- `out_illegal`  out  1  unsupported encoding
- `out_pc`  out  XLEN  pc passed through

## Operation
- `aluctrl` encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
- OP (0110011):
  - funct7 = 0000000 maps funct3 000/111/110/100/001/101/010/011 to add/and/or/xor/sll/srl/slt/sltu.
  - funct7 = 0100000 is legal only with funct3 000 (sub) and 101 (sra).
  - op1 = rs1, op2 = rs2, `reg_we` = 1.
- OP-IMM (0010011):
  - Same funct3 map, op2 = imm, I-immediate sign-extended from bit 31.
  - slli needs funct7 = 0000000.
  - srli/srai are selected by instr[30]; all other instr[31:25] values are illegal.
  - For shifts, imm = zero-extended instr[24:20].
  - No sub form exists.
- LUI (0110111): op1 = zero, op2 = imm = {instr[31:12], 12'b0}, add.
- AUIPC (0010111): op1 = pc, op2 = imm = {instr[31:12], 12'b0}, add.
- Any other opcode or illegal funct combination: `illegal` = 1, `reg_we` = 0, `aluctrl` = 0000, `imm` = 0. The word is still delivered with `out_valid` = 1.
- `rs1`/`rs2`/`rd` are always the raw fields instr[19:15], [24:20], [11:7].
- `reg_we` is forced to 0 when rd = 0.

## Timing
- Reset: `out_valid` = 0, every other output register = 0, so `aluctrl` = 0000 and `illegal` = 0.
- `in_ready` is combinational: `in_ready` = !`out_valid` || `out_ready`.
- Capture:
  - When `in_valid` && `in_ready` && !`flush`, decoded fields load and `out_valid` = 1 next cycle.
  - Latency is exactly 1 cycle; one instruction per cycle under full flow.
- Hold: while `out_valid` && !`out_ready`, all outputs stay stable and `in_ready` = 0.
- Drain: `out_valid` && `out_ready` && no capture gives `out_valid` = 0 next cycle.
- `flush`:
  - Clears `out_valid` next cycle and blocks capture in the same cycle, even with `in_valid` = 1.
  - Takes priority over every other event.
  - Data registers may keep stale values.
- Reset asserted mid-transfer drops the held word immediately.
- No combinational path from `in_instr` to any `out_*`.

## Structure
- Package `alu_pkg`:
  - `aluctrl_t` enum with the ten encodings above.
  - Opcode constants `OPC_OP`, `OPC_OPIMM`, `OPC_LUI`, `OPC_AUIPC`.
  - `op1_sel_t` and `op2_sel_t`.
  - The ALU moves to `aluctrl_t` as well.
- Sub-module `imm_gen`: combinational, instr in, I/U/shamt immediate out, selected by opcode and funct3.
- Stage body: combinational decode block plus the output register and handshake logic.

## Test plan
- `add x3,x1,x2` 0x002081B3, then `sub` 0x402081B3, back to back with `out_ready` = 1:
  - Consecutive cycles show `aluctrl` 0000 then 0001.
  - rs1 = 1, rs2 = 2, rd = 3, `op2_sel` = 0, `reg_we` = 1.
- `srai x5,x6,3` 0x40335293 gives `aluctrl` 0111, imm = 3, `op2_sel` = 1.
- `addi x1,x0,-1` 0xFFF00093 gives imm = 0xFFFFFFFF, `aluctrl` 0000.
- `lui x2,0x12345` 0x12345137 gives imm = 0x12345000, `op1_sel` = 10.
- `auipc` with pc = 0x100 gives `op1_sel` = 01 and `out_pc` = 0x100.
- Instruction 0x00000000 and `sub`-form funct7 with funct3 = 010 each give `illegal` = 1, `reg_we` = 0.
- Backpressure and flush:
  - `out_ready` = 0 for 3 cycles: outputs stable, `in_ready` = 0, the next instruction is not lost.
  - `flush` together with `in_valid` = 1 gives `out_valid` = 0 next cycle.
  - Async `rst` pulse mid-hold clears `out_valid` without a clock edge.
